game_controller: RTL and testbench

Round-level controller for the flappy-bird game, clocked on the game tick. It sits upstream of bird movement and column generation and downstream of collision detection and score calculation. It conditions the raw flap button into one-tick flap pulses and sequences each round through IDLE → PLAYING → DYING → GAME_OVER. It drives the freeze (`finished`) and round-restart controls and keeps the session high score for the 7-segment display.

---
 rtl/game_controller_pkg.sv | 14 +
 rtl/game_controller_if.sv | 24 ++
 rtl/btn_debounce.sv | 50 +++++
 rtl/game_controller.sv | 109 ++++++++++
 tb/tb_game_controller.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/game_controller_pkg.sv
// Shared state encodings and parameter defaults for the round controller.
package game_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_PLAYING  = 2'b01,
    ST_DYING    = 2'b10,
    ST_GAMEOVER = 2'b11
  } state_e;

  localparam int DEBOUNCE_TICKS_DEF = 3;
  localparam int DEATH_TICKS_DEF    = 60;

endpackage

// File: rtl/game_controller_if.sv
// Game-side signals of the round controller: button/collision/score in, control/display out.
interface game_controller_if #(
  parameter int SCORE_W = 10
);
  logic               btn;
  logic               hitColumn;
  logic [SCORE_W-1:0] score;
  logic               flap;
  logic               finished;
  logic               roundReset;
  logic [1:0]         state;
  logic [SCORE_W-1:0] highScore;
  logic               newRecord;

  modport master (
    output btn, hitColumn, score,
    input  flap, finished, roundReset, state, highScore, newRecord
  );

  modport slave (
    input  btn, hitColumn, score,
    output flap, finished, roundReset, state, highScore, newRecord
  );
endinterface

// File: rtl/btn_debounce.sv
// Synchronizes and debounces the raw flap button; press strobes on the debounced 0->1 edge.
module btn_debounce
  import game_controller_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
  input  logic gameClk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             s1_q, s2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d  = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Strobe is taken from the next-state so the FSM reacts on the very edge db rises.
  assign press = db_d & ~db_q;

  always_ff @(posedge gameClk) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= btn;
      s2_q  <= s1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_controller.sv
// Round sequencer IDLE -> PLAYING -> DYING -> GAME_OVER with flap pulses and session high score.
module game_controller
  import game_controller_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int DEATH_TICKS    = DEATH_TICKS_DEF,
  parameter int SCORE_W        = 10
) (
  input  logic             gameClk,
  input  logic             reset,
  game_controller_if.slave bus
);

  localparam int DW = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;
  localparam logic [DW-1:0] DEATH_LOAD = DW'(DEATH_TICKS - 1);

  logic press;

  btn_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_btn_debounce (
    .gameClk(gameClk),
    .reset  (reset),
    .btn    (bus.btn),
    .press  (press)
  );

  state_e             state_q, state_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic [SCORE_W-1:0] hs_q, hs_d;
  logic               nr_q, nr_d;
  logic               flap_q, flap_d;
  logic               rr_q, rr_d;
  logic               fin_q, fin_d;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    hs_d    = hs_q;
    nr_d    = nr_q;
    flap_d  = 1'b0;
    rr_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (press) begin
          state_d = ST_PLAYING;
          rr_d    = 1'b1;
          nr_d    = 1'b0;
        end
      end
      ST_PLAYING: begin
        // A hit outranks a simultaneous press: the round ends without a flap.
        if (bus.hitColumn) begin
          state_d = ST_DYING;
          dcnt_d  = DEATH_LOAD;
          if (bus.score > hs_q) begin
            hs_d = bus.score;
            nr_d = 1'b1;
          end else begin
            nr_d = 1'b0;
          end
        end else if (press) begin
          flap_d = 1'b1;
        end
      end
      ST_DYING: begin
        if (dcnt_q == '0) state_d = ST_GAMEOVER;
        else              dcnt_d  = dcnt_q - DW'(1);
      end
      ST_GAMEOVER: begin
        if (press) begin
          state_d = ST_IDLE;
          rr_d    = 1'b1;
          nr_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    fin_d = (state_d != ST_PLAYING);
  end

  always_ff @(posedge gameClk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dcnt_q  <= '0;
      hs_q    <= '0;
      nr_q    <= 1'b0;
      flap_q  <= 1'b0;
      rr_q    <= 1'b0;
      fin_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      hs_q    <= hs_d;
      nr_q    <= nr_d;
      flap_q  <= flap_d;
      rr_q    <= rr_d;
      fin_q   <= fin_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.flap       = flap_q;
  assign bus.roundReset = rr_q;
  assign bus.finished   = fin_q;
  assign bus.highScore  = hs_q;
  assign bus.newRecord  = nr_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller at default parameters (debounce 3, death 60).
module tb_game_controller;

  logic clk = 1'b0;
  logic reset;
  int   vec  = 0;
  int   errs = 0;
  int   flap_seen = 0;
  int   rr_seen   = 0;

  game_controller_if #(.SCORE_W(10)) bus ();

  game_controller #(
    .DEBOUNCE_TICKS(3),
    .DEATH_TICKS   (60),
    .SCORE_W       (10)
  ) dut (
    .gameClk(clk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // Advance one edge, then observe outputs 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.flap)       flap_seen++;
    if (bus.roundReset) rr_seen++;
  endtask

  // Press held from before edge 1; debounced press lands on edge 5.
  task automatic do_press();
    bus.btn = 1'b1;
    repeat (5) tick();
  endtask

  task automatic do_release();
    bus.btn = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.btn = 1'b0; bus.hitColumn = 1'b0; bus.score = '0;
    tick();
    reset = 1'b0;
    flap_seen = 0; rr_seen = 0;
    repeat (10) tick();
    vec++; if (bus.state !== 2'b00) begin errs++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
    vec++; if (bus.finished !== 1'b1) begin errs++; $display("FAIL reset_finished: got %0b expected 1", bus.finished); end
    vec++; if (flap_seen + rr_seen != 0) begin errs++; $display("FAIL reset_pulses: got %0d expected 0", flap_seen + rr_seen); end
    vec++; if (bus.highScore !== 10'd0) begin errs++; $display("FAIL reset_highscore: got %0d expected 0", bus.highScore); end
    vec++; if (bus.newRecord !== 1'b0) begin errs++; $display("FAIL reset_newrecord: got %0b expected 0", bus.newRecord); end
  endtask

  task automatic test_glitch_and_start();
    rr_seen = 0;
    bus.btn = 1'b1;
    repeat (2) tick();
    bus.btn = 1'b0;
    repeat (8) tick();
    vec++; if (bus.state !== 2'b00 || rr_seen != 0) begin errs++; $display("FAIL glitch_reject: state %0d rr %0d expected 0 0", bus.state, rr_seen); end
    bus.btn = 1'b1;
    repeat (4) tick();
    vec++; if (bus.state !== 2'b00) begin errs++; $display("FAIL start_early: got %0d expected 0", bus.state); end
    tick();
    vec++; if (bus.state !== 2'b01) begin errs++; $display("FAIL start_state: got %0d expected 1", bus.state); end
    vec++; if (bus.roundReset !== 1'b1 || bus.flap !== 1'b0) begin errs++; $display("FAIL start_pulses: rr %0b flap %0b expected 1 0", bus.roundReset, bus.flap); end
    vec++; if (bus.finished !== 1'b0) begin errs++; $display("FAIL start_finished: got %0b expected 0", bus.finished); end
    tick();
    vec++; if (bus.roundReset !== 1'b0) begin errs++; $display("FAIL start_rr_width: got %0b expected 0", bus.roundReset); end
    do_release();
  endtask

  task automatic test_flaps();
    int total = 0;
    for (int k = 0; k < 3; k++) begin
      flap_seen = 0;
      bus.btn = 1'b1;
      repeat (4) tick();
      vec++; if (bus.flap !== 1'b0) begin errs++; $display("FAIL flap_early[%0d]: got %0b expected 0", k, bus.flap); end
      tick();
      vec++; if (bus.flap !== 1'b1) begin errs++; $display("FAIL flap_pulse[%0d]: got %0b expected 1", k, bus.flap); end
      repeat (3) tick();
      do_release();
      vec++; if (flap_seen != 1) begin errs++; $display("FAIL flap_count[%0d]: got %0d expected 1", k, flap_seen); end
      total += flap_seen;
    end
    vec++; if (total != 3 || bus.state !== 2'b01) begin errs++; $display("FAIL flap_total: got %0d state %0d expected 3 1", total, bus.state); end
  endtask

  task automatic test_hit_with_press();
    bus.score = 10'd7;
    flap_seen = 0;
    bus.btn = 1'b1;
    repeat (4) tick();
    bus.hitColumn = 1'b1;
    tick();
    bus.hitColumn = 1'b0;
    bus.btn = 1'b0;
    vec++; if (bus.state !== 2'b10) begin errs++; $display("FAIL hit_state: got %0d expected 2", bus.state); end
    vec++; if (bus.finished !== 1'b1 || flap_seen != 0) begin errs++; $display("FAIL hit_nopress: fin %0b flaps %0d expected 1 0", bus.finished, flap_seen); end
    vec++; if (bus.highScore !== 10'd7 || bus.newRecord !== 1'b1) begin errs++; $display("FAIL hit_record: hs %0d nr %0b expected 7 1", bus.highScore, bus.newRecord); end
    repeat (59) tick();
    vec++; if (bus.state !== 2'b10) begin errs++; $display("FAIL dying_len: got %0d expected 2", bus.state); end
    tick();
    vec++; if (bus.state !== 2'b11 || bus.finished !== 1'b1) begin errs++; $display("FAIL gameover: state %0d fin %0b expected 3 1", bus.state, bus.finished); end
    vec++; if (flap_seen != 0) begin errs++; $display("FAIL dying_flap: got %0d expected 0", flap_seen); end
  endtask

  task automatic test_second_round();
    do_press();
    vec++; if (bus.state !== 2'b00 || bus.roundReset !== 1'b1) begin errs++; $display("FAIL go_to_idle: state %0d rr %0b expected 0 1", bus.state, bus.roundReset); end
    vec++; if (bus.newRecord !== 1'b0 || bus.highScore !== 10'd7) begin errs++; $display("FAIL rr_clears_nr: nr %0b hs %0d expected 0 7", bus.newRecord, bus.highScore); end
    do_release();
    do_press();
    vec++; if (bus.state !== 2'b01 || bus.flap !== 1'b0) begin errs++; $display("FAIL round2_start: state %0d flap %0b expected 1 0", bus.state, bus.flap); end
    do_release();
    bus.score = 10'd5;
    bus.hitColumn = 1'b1;
    tick();
    bus.hitColumn = 1'b0;
    vec++; if (bus.state !== 2'b10 || bus.highScore !== 10'd7 || bus.newRecord !== 1'b0) begin errs++; $display("FAIL round2_hit: state %0d hs %0d nr %0b expected 2 7 0", bus.state, bus.highScore, bus.newRecord); end
    repeat (60) tick();
    vec++; if (bus.state !== 2'b11) begin errs++; $display("FAIL round2_gameover: got %0d expected 3", bus.state); end
    rr_seen = 0;
    do_press();
    vec++; if (bus.state !== 2'b00 || bus.roundReset !== 1'b1) begin errs++; $display("FAIL round2_idle: state %0d rr %0b expected 0 1", bus.state, bus.roundReset); end
    do_release();
    vec++; if (rr_seen != 1) begin errs++; $display("FAIL round2_rr_width: got %0d expected 1", rr_seen); end
  endtask

  task automatic test_reset_mid_dying();
    do_press();
    do_release();
    bus.score = 10'd3;
    bus.hitColumn = 1'b1;
    tick();
    bus.hitColumn = 1'b0;
    repeat (20) tick();
    vec++; if (bus.state !== 2'b10) begin errs++; $display("FAIL pre_reset_state: got %0d expected 2", bus.state); end
    reset = 1'b1; bus.btn = 1'b1; bus.hitColumn = 1'b1;
    tick();
    reset = 1'b0; bus.btn = 1'b0; bus.hitColumn = 1'b0;
    vec++; if (bus.state !== 2'b00 || bus.finished !== 1'b1) begin errs++; $display("FAIL midreset_state: state %0d fin %0b expected 0 1", bus.state, bus.finished); end
    vec++; if (bus.highScore !== 10'd0 || bus.newRecord !== 1'b0) begin errs++; $display("FAIL midreset_hs: hs %0d nr %0b expected 0 0", bus.highScore, bus.newRecord); end
    vec++; if (bus.flap !== 1'b0 || bus.roundReset !== 1'b0) begin errs++; $display("FAIL midreset_pulses: flap %0b rr %0b expected 0 0", bus.flap, bus.roundReset); end
    repeat (8) tick();
    bus.hitColumn = 1'b1;
    tick();
    bus.hitColumn = 1'b0;
    tick();
    vec++; if (bus.state !== 2'b00 || bus.highScore !== 10'd0) begin errs++; $display("FAIL idle_hit: state %0d hs %0d expected 0 0", bus.state, bus.highScore); end
  endtask

  task automatic test_max_score();
    do_press();
    do_release();
    bus.score = 10'h3FF;
    bus.hitColumn = 1'b1;
    tick();
    bus.hitColumn = 1'b0;
    vec++; if (bus.highScore !== 10'h3FF || bus.newRecord !== 1'b1) begin errs++; $display("FAIL max_score: hs %0d nr %0b expected 1023 1", bus.highScore, bus.newRecord); end
  endtask

  initial begin
    reset = 1'b1;
    bus.btn = 1'b0;
    bus.hitColumn = 1'b0;
    bus.score = '0;
    test_reset();
    test_glitch_and_start();
    test_flaps();
    test_hit_with_press();
    test_second_round();
    test_reset_mid_dying();
    test_max_score();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
